game_input_ctrl: RTL and testbench
==================================

GAME_INPUT_CTRL -- requirements
Module: game_input_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, consecutive stable cycles needed to accept a button level change (5 ms at 50 MHz).
REQ-002 SHALL have parameter DB_W, default 18, debounce counter width; DB_W SHALL be large enough to hold DEBOUNCE_CYCLES.
REQ-003 SHALL have parameter LONG_PRESS_CYCLES, default 100000000, debounced start-hold cycles that trigger a reset request (2 s at 50 MHz).
REQ-004 SHALL have parameter LP_W, default 27, long-press counter width.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 btn_start_n  input  1  raw start pushbutton, active-low, asynchronous to clk.
REQ-008 btn_pause_n  input  1  raw pause pushbutton, active-low, asynchronous to clk.
REQ-009 btn_reset_n  input  1  raw reset pushbutton, active-low, asynchronous to clk.
REQ-010 startGame  output  1  one-cycle start pulse for the game state machine.
REQ-011 pauseGame  output  1  one-cycle pause pulse for the game state machine.
REQ-012 resetGame  output  1  one-cycle game-reset request pulse for the game state machine.
REQ-013 btn_level  output  3  debounced pressed levels {reset, pause, start}, 1 = pressed.

Function
REQ-014 Each raw button SHALL pass through a 2-flop synchronizer and be inverted to active-high before any other logic sees it.
REQ-015 Each channel SHALL keep a debounced level and a DB_W-bit counter.
REQ-016 Counter behaviour: it increments while the synchronized value differs from the debounced level and clears to 0 when they match.
REQ-017 When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, the debounced level SHALL take the synchronized value on that edge and the counter SHALL clear.
REQ-018 A mismatch lasting fewer than DEBOUNCE_CYCLES cycles (bounce or glitch) SHALL leave the debounced level unchanged and produce no pulse.
REQ-019 A pulse SHALL be registered and high for exactly one cycle, in the cycle after the channel's debounced level goes 0->1; a release (1->0) SHALL produce no pulse.
REQ-020 Latency: for a raw press held from edge k, the pulse SHALL be high in the cycle following edge k+DEBOUNCE_CYCLES+3.
REQ-021 A held button SHALL produce only one pulse per press, however long it is held.
REQ-022 Simultaneous pulses: when more than one pulse qualifies in a cycle, priority is resetGame > pauseGame > startGame; lower-priority pulses are dropped, not deferred.
REQ-023 At most one of startGame, pauseGame and resetGame SHALL be high in any cycle.
REQ-024 btn_level SHALL equal the debounced levels, registered, with no further delay.

Reset
REQ-025 While reset is high, these SHALL be 0: synchronizer flops, debounced levels, all counters, startGame, pauseGame, resetGame and btn_level.
REQ-026 reset SHALL take effect on the next clk edge and override every other event, including an in-progress debounce or long-press count.
REQ-027 A button held through reset release SHALL be treated as a new press and pulse per REQ-020, counted from the first edge after reset is released.

Configuration
REQ-028 The macro LONG_PRESS_RESET_EN SHALL control the long-press reset feature.
REQ-029 With LONG_PRESS_RESET_EN defined: a long-press counter counts cycles while the debounced start level is 1.
REQ-030 With LONG_PRESS_RESET_EN defined: the counter clears when that level is 0.
REQ-031 With LONG_PRESS_RESET_EN defined: on reaching LONG_PRESS_CYCLES-1 it SHALL issue one resetGame pulse (arbitrated per REQ-022), then saturate until release, so there is one long-press pulse per hold.
REQ-032 With LONG_PRESS_RESET_EN defined: the normal startGame pulse on press is still issued.
REQ-033 With LONG_PRESS_RESET_EN undefined: no long-press counter SHALL exist and resetGame SHALL come only from btn_reset_n.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20)
REQ-034 Clean press: btn_start_n low at edge 10 and held -> startGame high for exactly the cycle after edge 17; no further pulses while held.
REQ-035 Bounce: btn_pause_n low for 3 cycles, high 1 cycle, low held -> a single pauseGame pulse, 7 cycles after the final low edge.
REQ-036 Simultaneous press: btn_start_n and btn_reset_n low on the same edge -> resetGame pulses once and startGame stays 0 throughout.
REQ-037 Reset mid-debounce: btn_start_n low, reset high 1 cycle at edge 3 of the count -> all outputs 0; startGame pulses 7 cycles after reset is released.
REQ-038 Long press with LONG_PRESS_RESET_EN: hold start 40 cycles -> one startGame pulse, then exactly one resetGame pulse 20 cycles after the debounced level rises; without the macro, no resetGame pulse.

Source files
------------

// File: rtl/game_input_ctrl.sv
`default_nettype none
//============================================================================
// Module   : game_input_ctrl
// Purpose  : Conditions three raw active-low pushbuttons (start, pause, reset)
//            for a game state machine. Each button is synchronized, inverted
//            to active-high and debounced. A debounced press (0->1) becomes a
//            registered one-cycle pulse. When pulses coincide, the outputs are
//            arbitrated as resetGame > pauseGame > startGame, and the losers
//            are dropped.
// Ports    : clk          - system clock, rising edge
//            reset        - synchronous active-high reset
//            btn_start_n  - raw start button, active-low, asynchronous
//            btn_pause_n  - raw pause button, active-low, asynchronous
//            btn_reset_n  - raw reset button, active-low, asynchronous
//            startGame    - one-cycle start pulse
//            pauseGame    - one-cycle pause pulse
//            resetGame    - one-cycle game-reset request pulse
//            btn_level    - debounced pressed levels {reset, pause, start}
// Options  : define LONG_PRESS_RESET_EN so that holding start for
//            LONG_PRESS_CYCLES debounced cycles also raises one resetGame
//            pulse per hold.
// Revision : 1.0 - initial release
//============================================================================
module game_input_ctrl #(
   parameter int DEBOUNCE_CYCLES   = 250000,
   parameter int DB_W              = 18,
   parameter int LONG_PRESS_CYCLES = 100000000,
   parameter int LP_W              = 27
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start_n,
   input  logic       btn_pause_n,
   input  logic       btn_reset_n,
   output logic       startGame,
   output logic       pauseGame,
   output logic       resetGame,
   output logic [2:0] btn_level
);

   // Channel index: 0 = start, 1 = pause, 2 = reset
   localparam logic [DB_W-1:0] c_DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   // Parameter sanity checks, evaluated at elaboration time
   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** DB_W)) begin : g_db_w_chk
      $error("game_input_ctrl: DB_W too small for DEBOUNCE_CYCLES");
   end
   // The long-press counter saturates at LONG_PRESS_CYCLES, so it must fit
   if (LONG_PRESS_CYCLES < 1 || LONG_PRESS_CYCLES >= (2 ** LP_W)) begin : g_lp_w_chk
      $error("game_input_ctrl: LP_W too small for LONG_PRESS_CYCLES");
   end

   logic [2:0] sync1_q;
   logic [2:0] sync2_q;
   logic [2:0] level_q;
   logic [2:0] level_d;
   logic [2:0] prev_q;
   logic [2:0] rise_q;
   logic       start_q, start_d;
   logic       pause_q, pause_d;
   logic       rst_q,   rst_d;
   logic       w_lp_hit;
   logic       w_reset_req;

   //------------------------------------------------------------------------
   // Two-flop synchronizer; inversion happens before the first flop so that
   // everything downstream sees active-high levels.
   //------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= ~{btn_reset_n, btn_pause_n, btn_start_n};
         sync2_q <= sync1_q;
      end
   end

   //------------------------------------------------------------------------
   // Per-channel debounce: the counter runs only while the synchronized
   // value disagrees with the accepted level. Any agreement restarts it, so
   // only an unbroken run of DEBOUNCE_CYCLES mismatches moves the level.
   //------------------------------------------------------------------------
   for (genvar i = 0; i < 3; i++) begin : g_ch
      logic [DB_W-1:0] cnt_q;
      logic [DB_W-1:0] cnt_d;
      logic            lvl_d;

      always_comb begin
         cnt_d = '0;
         lvl_d = level_q[i];
         if (sync2_q[i] != level_q[i]) begin
            if (cnt_q == c_DB_LAST) begin
               lvl_d = sync2_q[i];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign level_d[i] = lvl_d;
   end

   //------------------------------------------------------------------------
   // Optional long-press detector on the debounced start level. The counter
   // stops one past the trigger value, so each hold yields exactly one hit.
   //------------------------------------------------------------------------
`ifdef LONG_PRESS_RESET_EN
   localparam logic [LP_W-1:0] c_LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [LP_W-1:0] c_LP_SAT  = LP_W'(LONG_PRESS_CYCLES);

   logic [LP_W-1:0] lp_cnt_q;
   logic [LP_W-1:0] lp_cnt_d;

   always_comb begin
      lp_cnt_d = lp_cnt_q;
      if (!level_q[0]) begin
         lp_cnt_d = '0;
      end else if (lp_cnt_q != c_LP_SAT) begin
         lp_cnt_d = lp_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lp_cnt_q <= '0;
      end else begin
         lp_cnt_q <= lp_cnt_d;
      end
   end

   assign w_lp_hit = level_q[0] && (lp_cnt_q == c_LP_LAST);
`else
   assign w_lp_hit = 1'b0;
`endif

   //------------------------------------------------------------------------
   // Edge detection and output arbitration. A rise is captured one cycle
   // after the level changes, then arbitrated into the output registers.
   // Losing requests are discarded, not queued.
   //------------------------------------------------------------------------
   assign w_reset_req = rise_q[2] | w_lp_hit;

   always_comb begin
      start_d = 1'b0;
      pause_d = 1'b0;
      rst_d   = 1'b0;
      if (w_reset_req) begin
         rst_d = 1'b1;
      end else if (rise_q[1]) begin
         pause_d = 1'b1;
      end else if (rise_q[0]) begin
         start_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         level_q <= '0;
         prev_q  <= '0;
         rise_q  <= '0;
         start_q <= 1'b0;
         pause_q <= 1'b0;
         rst_q   <= 1'b0;
      end else begin
         level_q <= level_d;
         prev_q  <= level_q;
         rise_q  <= level_q & ~prev_q;
         start_q <= start_d;
         pause_q <= pause_d;
         rst_q   <= rst_d;
      end
   end

   assign startGame = start_q;
   assign pauseGame = pause_q;
   assign resetGame = rst_q;
   assign btn_level = level_q;

endmodule
`default_nettype wire

// File: tb/tb_game_input_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_game_input_ctrl
// Purpose  : Directed self-checking bench for game_input_ctrl. It uses
//            DEBOUNCE_CYCLES=4 and LONG_PRESS_CYCLES=20. A press applied
//            just after edge c is first sampled at edge c+1, and its pulse
//            is expected in the cycle after edge c+8.
// Revision : 1.0 - initial release
//============================================================================
module tb_game_input_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       bs, bp, br;
   logic       sg, pg, rg;
   logic [2:0] lvl;

   int n_tests = 0;
   int n_fail  = 0;
   int ns, np, nr;

`ifdef LONG_PRESS_RESET_EN
   localparam int c_LP_EXP = 1;
`else
   localparam int c_LP_EXP = 0;
`endif

   always #5 clk = ~clk;

   game_input_ctrl #(
      .DEBOUNCE_CYCLES   (4),
      .DB_W              (3),
      .LONG_PRESS_CYCLES (20),
      .LP_W              (5)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_start_n (bs),
      .btn_pause_n (bp),
      .btn_reset_n (br),
      .startGame   (sg),
      .pauseGame   (pg),
      .resetGame   (rg),
      .btn_level   (lvl)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit after the last one
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Advance n cycles, tallying pulses and checking mutual exclusion
   task automatic count(input int n, output int cs, output int cp, output int cr);
      cs = 0;
      cp = 0;
      cr = 0;
      repeat (n) begin
         tick(1);
         cs += int'(sg);
         cp += int'(pg);
         cr += int'(rg);
         chk("onehot", 32'($onehot0({sg, pg, rg})), 32'd1);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bs = 1'b1; bp = 1'b1; br = 1'b1;
      tick(3);
      chk("rst_start", 32'(sg), 32'd0);
      chk("rst_pause", 32'(pg), 32'd0);
      chk("rst_reset", 32'(rg), 32'd0);
      chk("rst_level", 32'(lvl), 32'd0);
      reset = 1'b0;
      tick(5);

      // Clean start press
      bs = 1'b0;
      tick(5);
      chk("clean_lvl_early", 32'(lvl), 32'd0);
      tick(1);
      chk("clean_lvl_set", 32'(lvl), 32'd1);
      tick(1);
      chk("clean_start_early", 32'(sg), 32'd0);
      tick(1);
      chk("clean_start_pulse", 32'(sg), 32'd1);
      chk("clean_pause_quiet", 32'(pg), 32'd0);
      chk("clean_reset_quiet", 32'(rg), 32'd0);
      count(8, ns, np, nr);
      chk("clean_held_start", 32'(ns), 32'd0);
      chk("clean_held_reset", 32'(nr), 32'd0);
      bs = 1'b1;
      count(12, ns, np, nr);
      chk("clean_release_pulses", 32'(ns + np + nr), 32'd0);
      chk("clean_release_lvl", 32'(lvl), 32'd0);

      // Bounce on pause: 3 low, 1 high, then held low
      bp = 1'b0;
      tick(3);
      bp = 1'b1;
      tick(1);
      bp = 1'b0;
      count(7, ns, np, nr);
      chk("bounce_no_early", 32'(ns + np + nr), 32'd0);
      tick(1);
      chk("bounce_pause_pulse", 32'(pg), 32'd1);
      count(8, ns, np, nr);
      chk("bounce_single", 32'(np), 32'd0);
      bp = 1'b1;
      count(10, ns, np, nr);
      chk("bounce_release", 32'(ns + np + nr), 32'd0);

      // Simultaneous start + pause: pause wins, start dropped
      bs = 1'b0; bp = 1'b0;
      count(7, ns, np, nr);
      chk("sp_no_early", 32'(ns + np + nr), 32'd0);
      tick(1);
      chk("sp_pause_pulse", 32'(pg), 32'd1);
      chk("sp_start_dropped", 32'(sg), 32'd0);
      count(8, ns, np, nr);
      chk("sp_no_late_start", 32'(ns + np + nr), 32'd0);
      chk("sp_level", 32'(lvl), 32'd3);
      bs = 1'b1; bp = 1'b1;
      count(10, ns, np, nr);
      chk("sp_release", 32'(ns + np + nr), 32'd0);

      // Simultaneous start + reset: reset wins, start never pulses
      bs = 1'b0; br = 1'b0;
      count(7, ns, np, nr);
      chk("sr_no_early", 32'(ns + np + nr), 32'd0);
      tick(1);
      chk("sr_reset_pulse", 32'(rg), 32'd1);
      chk("sr_start_dropped", 32'(sg), 32'd0);
      count(8, ns, np, nr);
      chk("sr_no_late", 32'(ns + np + nr), 32'd0);
      chk("sr_level", 32'(lvl), 32'd5);
      bs = 1'b1; br = 1'b1;
      count(10, ns, np, nr);
      chk("sr_release", 32'(ns + np + nr), 32'd0);

      // Reset mid-debounce: start held through a one-cycle reset
      bs = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(1);
      chk("mid_rst_outputs", 32'({sg, pg, rg}), 32'd0);
      chk("mid_rst_level", 32'(lvl), 32'd0);
      reset = 1'b0;
      count(7, ns, np, nr);
      chk("mid_no_early", 32'(ns), 32'd0);
      tick(1);
      chk("mid_start_pulse", 32'(sg), 32'd1);
      tick(1);
      chk("mid_start_single", 32'(sg), 32'd0);
      bs = 1'b1;
      count(10, ns, np, nr);
      chk("mid_release", 32'(ns + np + nr), 32'd0);

      // Reset clears an accepted level; a held button re-presses afterwards
      bp = 1'b0;
      count(12, ns, np, nr);
      chk("held_pause_pulses", 32'(np), 32'd1);
      chk("held_pause_level", 32'(lvl), 32'd2);
      reset = 1'b1;
      tick(1);
      chk("held_rst_level", 32'(lvl), 32'd0);
      reset = 1'b0;
      count(7, ns, np, nr);
      chk("held_no_early", 32'(np), 32'd0);
      tick(1);
      chk("held_repress_pulse", 32'(pg), 32'd1);
      bp = 1'b1;
      count(10, ns, np, nr);
      chk("held_release", 32'(ns + np + nr), 32'd0);

      // Long hold of start for 40 cycles
      bs = 1'b0;
      count(7, ns, np, nr);
      chk("lp_no_early", 32'(ns + np + nr), 32'd0);
      tick(1);
      chk("lp_start_pulse", 32'(sg), 32'd1);
      count(17, ns, np, nr);
      chk("lp_quiet_before", 32'(ns + np + nr), 32'd0);
      tick(1);
      chk("lp_reset_pulse", 32'(rg), 32'(c_LP_EXP));
      count(14, ns, np, nr);
      chk("lp_quiet_after", 32'(ns + np + nr), 32'd0);
      bs = 1'b1;
      count(12, ns, np, nr);
      chk("lp_release", 32'(ns + np + nr), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
